// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display path: segment patterns,
// ASCII codes and the receive-side settle FSM encoding.
package sevenseg_pkg;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] NUM_0 = 7'b1000000;
  localparam logic [6:0] NUM_1 = 7'b1111001;
  localparam logic [6:0] NUM_2 = 7'b0100100;
  localparam logic [6:0] NUM_3 = 7'b0110000;
  localparam logic [6:0] NUM_4 = 7'b0011001;
  localparam logic [6:0] NUM_5 = 7'b0010010;
  localparam logic [6:0] NUM_6 = 7'b0000010;
  localparam logic [6:0] NUM_7 = 7'b1111000;
  localparam logic [6:0] NUM_8 = 7'b0000000;
  localparam logic [6:0] NUM_9 = 7'b0010000;

  localparam logic [6:0] CHAR_A    = 7'b0001000;
  localparam logic [6:0] CHAR_B    = 7'b0000011;
  localparam logic [6:0] CHAR_C    = 7'b1000110;
  localparam logic [6:0] CHAR_D    = 7'b0100001;
  localparam logic [6:0] CHAR_E    = 7'b0000110;
  localparam logic [6:0] CHAR_F    = 7'b0001110;
  localparam logic [6:0] CHAR_H    = 7'b0001001;
  localparam logic [6:0] CHAR_K    = 7'b0001111;
  localparam logic [6:0] CHAR_L    = 7'b1000111;
  localparam logic [6:0] CHAR_P    = 7'b0001100;
  localparam logic [6:0] CHAR_LO_O = 7'b0100011;

  localparam logic [6:0] SPACE     = 7'b1111111;
  localparam logic [6:0] HYPHEN    = 7'b0111111;
  localparam logic [6:0] UNDERLINE = 7'b1110111;
  localparam logic [6:0] OVERLINE  = 7'b1111110;

  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } settle_state_e;

  // True when exactly one anode strobe is active (low)
  function automatic logic strobe_valid(input logic [3:0] an);
    logic v;
    case (an)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  // Digit index selected by a valid strobe: an[3] low is digit 0
  function automatic logic [1:0] strobe_digit(input logic [3:0] an);
    logic [1:0] d;
    case (an)
      4'b0111: d = 2'd0;
      4'b1011: d = 2'd1;
      4'b1101: d = 2'd2;
      4'b1110: d = 2'd3;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational decode of an active-low 7-segment glyph to ASCII.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [7:0] ascii
);

  // Aliased glyphs (G, S, T) share patterns with 6, 5, 7 and decode as digits
  always_comb begin
    ascii = ASCII_UNKNOWN;
    case (pattern)
      NUM_0:     ascii = "0";
      NUM_1:     ascii = "1";
      NUM_2:     ascii = "2";
      NUM_3:     ascii = "3";
      NUM_4:     ascii = "4";
      NUM_5:     ascii = "5";
      NUM_6:     ascii = "6";
      NUM_7:     ascii = "7";
      NUM_8:     ascii = "8";
      NUM_9:     ascii = "9";
      CHAR_A:    ascii = "A";
      CHAR_B:    ascii = "B";
      CHAR_C:    ascii = "C";
      CHAR_D:    ascii = "D";
      CHAR_E:    ascii = "E";
      CHAR_F:    ascii = "F";
      CHAR_H:    ascii = "H";
      CHAR_K:    ascii = "K";
      CHAR_L:    ascii = "L";
      CHAR_P:    ascii = "P";
      CHAR_LO_O: ascii = "o";
      SPACE:     ascii = ASCII_SPACE;
      HYPHEN:    ascii = "-";
      UNDERLINE: ascii = "_";
      OVERLINE:  ascii = ASCII_UNKNOWN;
      default:   ascii = ASCII_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Receive side of the multiplexed seven-segment bus: synchronises seg/an,
// waits for each strobe to settle, captures one glyph per dwell and publishes
// all four characters atomically once every digit of a frame has been seen.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 262144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic [3:0] an,
  output logic [7:0] char_0,
  output logic [7:0] char_1,
  output logic [7:0] char_2,
  output logic [7:0] char_3,
  output logic [3:0] dp,
  output logic       frame_valid,
  output logic       frame_changed,
  output logic       stale
);

  localparam int unsigned ToW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToMax  = ToW'(TIMEOUT_CYCLES);
  localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);

  logic [SYNC_STAGES-1:0][7:0] seg_sync_q;
  logic [SYNC_STAGES-1:0][3:0] an_sync_q;
  logic [7:0] seg_s;
  logic [3:0] an_s;

  settle_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] an_l_q, an_l_d;
  logic [7:0] seg_l_q, seg_l_d;
  logic       capture;
  logic       an_valid;
  logic       stable;

  logic [1:0]      cap_idx;
  logic [7:0]      glyph;
  logic [3:0][7:0] shadow_char_q, shadow_char_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [3:0]      mask_q, mask_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout_hit;
  logic            commit;
  logic            changed;
  logic            stale_q, stale_d;

  logic [3:0][7:0] char_q;
  logic [3:0]      dp_q;
  logic            frame_valid_q;
  logic            frame_changed_q;

  // Input synchronizer chains; the oldest stage feeds all further logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_sync_q <= '0;
      an_sync_q  <= '0;
    end else begin
      seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg};
      an_sync_q  <= {an_sync_q[SYNC_STAGES-2:0], an};
    end
  end

  assign seg_s    = seg_sync_q[SYNC_STAGES-1];
  assign an_s     = an_sync_q[SYNC_STAGES-1];
  assign an_valid = strobe_valid(an_s);
  assign stable   = (an_s == an_l_q) && (seg_s == seg_l_q);
  assign cap_idx  = strobe_digit(an_s);

  sevenseg_glyph_decode u_decode (
    .pattern (seg_s[6:0]),
    .ascii   (glyph)
  );

  // Settle FSM next state: count stable cycles, capture once per dwell
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_l_d  = an_l_q;
    seg_l_d = seg_l_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (an_valid) begin
          state_d = StSettle;
          cnt_d   = 8'd1;
          an_l_d  = an_s;
          seg_l_d = seg_s;
        end else begin
          cnt_d = 8'd0;
        end
      end
      StSettle: begin
        if (!an_valid) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (!stable) begin
          cnt_d   = 8'd1;
          an_l_d  = an_s;
          seg_l_d = seg_s;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (!stable) begin
          if (an_valid) begin
            state_d = StSettle;
            cnt_d   = 8'd1;
            an_l_d  = an_s;
            seg_l_d = seg_s;
          end else begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
    // Checked on the new count so SETTLE_CYCLES = 1 captures on first sight
    if (state_d == StSettle && cnt_d == SettleMax) begin
      capture = 1'b1;
      state_d = StHold;
    end
  end

  // Shadow, mask, timeout and stale next state; capture lands after commit clear
  always_comb begin
    commit        = (mask_q == 4'b1111);
    changed       = commit && ({shadow_char_q, shadow_dp_q} != {char_q, dp_q});
    to_cnt_d      = capture ? '0 : ((to_cnt_q == ToMax) ? ToMax : to_cnt_q + 1'b1);
    timeout_hit   = !capture && (to_cnt_d == ToMax);
    mask_d        = mask_q;
    shadow_char_d = shadow_char_q;
    shadow_dp_d   = shadow_dp_q;
    stale_d       = stale_q;
    if (commit || timeout_hit) begin
      mask_d = 4'b0000;
    end
    if (timeout_hit) begin
      stale_d = 1'b1;
    end
    if (capture) begin
      mask_d[cap_idx]        = 1'b1;
      shadow_char_d[cap_idx] = glyph;
      shadow_dp_d[cap_idx]   = ~seg_s[7];
      stale_d                = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 8'd0;
      an_l_q          <= 4'b1111;
      seg_l_q         <= 8'hFF;
      shadow_char_q   <= {4{ASCII_SPACE}};
      shadow_dp_q     <= 4'b0000;
      mask_q          <= 4'b0000;
      to_cnt_q        <= '0;
      stale_q         <= 1'b1;
      char_q          <= {4{ASCII_SPACE}};
      dp_q            <= 4'b0000;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      an_l_q          <= an_l_d;
      seg_l_q         <= seg_l_d;
      shadow_char_q   <= shadow_char_d;
      shadow_dp_q     <= shadow_dp_d;
      mask_q          <= mask_d;
      to_cnt_q        <= to_cnt_d;
      stale_q         <= stale_d;
      frame_valid_q   <= commit;
      frame_changed_q <= changed;
      if (commit) begin
        char_q <= shadow_char_q;
        dp_q   <= shadow_dp_q;
      end
    end
  end

  assign char_0        = char_q[0];
  assign char_1        = char_q[1];
  assign char_2        = char_q[2];
  assign char_3        = char_q[3];
  assign dp            = dp_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign stale         = stale_q;

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive side of the multiplexed seven-segment interface: samples the active-low cathode bus `seg` and the active-low anode strobes `an` driven by the display scanner.
- Recovers the four ASCII characters and decimal points, and publishes them atomically once per complete scan frame.
- Used as an on-chip loopback monitor and as the bench-side checker for the display path.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on `seg` and `an` (minimum 2).
- SETTLE_CYCLES, 16, consecutive cycles the anode/segment pair must be stable before capture (range 1..255).
- TIMEOUT_CYCLES, 262144, cycles without any capture before the link is declared stale (2x a full 2^17-cycle scan).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- seg  input  8  cathodes, active-low, bit order Hgfedcba (bit7 = decimal point)
- an  input  4  anodes, active-low
- char_0  output  8  ASCII of digit 0 (enabled by an[3] low)
- char_1  output  8  ASCII of digit 1 (an[2] low)
- char_2  output  8  ASCII of digit 2 (an[1] low)
- char_3  output  8  ASCII of digit 3 (an[0] low)
- dp  output  4  decimal point per digit; dp[i] = 1 when seg[7] was low for digit i
- frame_valid  output  1  one-cycle pulse when char_*/dp update
- frame_changed  output  1  one-cycle pulse, coincident with frame_valid, if any char/dp differs from previous frame
- stale  output  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Interface: one clock `clk`; `rst` asynchronous, active-high. All flops clear on rst assertion; release is synchronous to clk.
- Reset values: char_0..3 = 8'h20, dp = 0, frame_valid = 0, frame_changed = 0, stale = 1, capture mask = 0, settle counter = 0, timeout counter = 0.
- Synchronizer: seg and an each pass through SYNC_STAGES flops. All further logic uses the synchronized values.
- Strobe qualification: an_s is valid only when exactly one bit is 0. Values 4'b1111 (blanking) and multi-low (ghost) are ignored, and they reset the settle counter.
- Settle FSM, states IDLE / SETTLE / HOLD:
  - IDLE: on a valid an_s, go to SETTLE with counter = 1 and latch an_s and seg_s.
  - SETTLE: if an_s or seg_s differs from the latch, restart (counter = 1, relatch), or go to IDLE if an_s is invalid. Otherwise increment. When counter reaches SETTLE_CYCLES, capture and go to HOLD.
  - HOLD: stay while an_s and seg_s are unchanged, so exactly one capture per strobe dwell. Any change returns to IDLE (or straight to SETTLE if the new an_s is valid).
- Capture latency: SYNC_STAGES + SETTLE_CYCLES cycles after the input change.
- Capture action: digit index i = 3 - (position of the low bit in an_s).
  - Write glyph_decode(seg[6:0]) into shadow char i, and ~seg[7] into shadow dp i.
  - Set mask[i]. Clear the timeout counter and stale.
- Glyph decode (7-bit, gfedcba, active-low):
  - 1000000 -> '0'; 1111001 -> '1'; 0100100 -> '2'; 0110000 -> '3'; 0011001 -> '4'; 0010010 -> '5'; 0000010 -> '6'; 1111000 -> '7'; 0000000 -> '8'; 0010000 -> '9'.
  - 0001000 -> 'A'; 0000011 -> 'B'; 1000110 -> 'C'; 0100001 -> 'D'; 0000110 -> 'E'; 0001110 -> 'F'; 0001001 -> 'H'; 0001111 -> 'K'; 1000111 -> 'L'; 0001100 -> 'P'; 0100011 -> 'o'.
  - 1111111 -> 8'h20; 0111111 -> '-'; 1110111 -> '_'.
  - Any other pattern, including 1111110 (overline), -> 8'h3F '?'.
  - Aliased glyphs always decode to the digit: G -> '6', S -> '5', T -> '7'.
- Frame commit: the cycle after mask reaches 4'b1111:
  - Copy the shadow registers to char_0..3 and dp.
  - Pulse frame_valid.
  - Pulse frame_changed iff the new {chars, dp} differs from the registered outputs.
  - Clear mask.
  - If a capture occurs in the commit cycle, it is applied to the shadow and mask after the clear, so it is not lost.
- Recapture: re-capturing an already-set digit before the frame completes overwrites its shadow value; the mask is unchanged.
- Timeout: the counter increments every cycle without a capture and saturates.
  - On reaching TIMEOUT_CYCLES: set stale and clear mask. Outputs hold their last committed values.
  - The next capture clears stale.
- Reset mid-frame: all state is discarded and outputs return to their reset values.

Decomposition:
- sevenseg_pkg holds:
  - the segment pattern constants (NUM_0..9, CHAR_*, SPACE, HYPHEN, UNDERLINE, OVERLINE), shared with the display driver;
  - the settle FSM state encoding;
  - ASCII_UNKNOWN = 8'h3F and ASCII_SPACE = 8'h20.
- One combinational sub-module, sevenseg_glyph_decode (7-bit pattern in, 8-bit ASCII out), reused by the bench scoreboard.

Test Plan:
- Reset then idle with an = 4'b1111 -> chars all 8'h20, dp = 0, stale = 1, frame_valid never asserts; after 262144 cycles stale is still 1.
- Scan "12-A", each digit held 100 cycles, in order an = 0111/1011/1101/1110 with seg = F9, A4, BF, 88 -> one frame_valid pulse 1 cycle after the 4th capture. Outputs: char_0 = 8'h31, char_1 = 8'h32, char_2 = 8'h2D, char_3 = 8'h41, frame_changed = 1, stale = 0.
- Repeat the identical frame -> frame_valid = 1, frame_changed = 0. Then change digit 2 to seg = 0x40 ('0' with DP on) -> char_2 = 8'h30, dp = 4'b0100, frame_changed = 1.
- Glitch: an held 1110 for SETTLE_CYCLES-1 cycles, then 1111 -> no capture, mask unchanged. Ghost an = 1100 for 50 cycles -> no capture.
- Unknown patterns seg = 0xFE and 0xAA on digit 1 -> char_1 = 8'h3F. Alias seg = 0x82 -> '6'.
- Three digits captured, then no strobes for TIMEOUT_CYCLES -> stale = 1, mask cleared; the next full scan commits normally. Assert rst mid-frame -> outputs return immediately to reset values.
